// File: rtl/ecg_synth_pkg.sv
// Shared constants for the synthetic ECG source: state codes, PQRST segment
// boundaries, the QRS sample ROM and default rate clamps.
package ecg_synth_pkg;

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] IDLE = 4'd0;
  localparam logic [STATE_W-1:0] P_UP = 4'd1;
  localparam logic [STATE_W-1:0] P_DN = 4'd2;
  localparam logic [STATE_W-1:0] PR   = 4'd3;
  localparam logic [STATE_W-1:0] QRS  = 4'd4;
  localparam logic [STATE_W-1:0] ST   = 4'd5;
  localparam logic [STATE_W-1:0] T_UP = 4'd6;
  localparam logic [STATE_W-1:0] T_DN = 4'd7;
  localparam logic [STATE_W-1:0] TP   = 4'd8;

  // First sample index of each segment within a beat
  localparam int unsigned SEG_P_UP = 0;
  localparam int unsigned SEG_P_DN = 6;
  localparam int unsigned SEG_PR   = 12;
  localparam int unsigned SEG_QRS  = 18;
  localparam int unsigned SEG_ST   = 27;
  localparam int unsigned SEG_T_UP = 35;
  localparam int unsigned SEG_T_DN = 45;
  localparam int unsigned SEG_TP   = 55;

  localparam int unsigned R_PEAK_OFF = 4;

  localparam int unsigned DEF_BPM_MIN = 30;
  localparam int unsigned DEF_BPM_MAX = 200;

  localparam logic signed [7:0] QRS_ROM [9] = '{
    -8'sd5, -8'sd10, 8'sd30, 8'sd65, 8'sd100, 8'sd60, 8'sd20, -8'sd25, -8'sd12
  };

  // Bounded ROM lookup; indices past the table read as zero
  function automatic logic signed [7:0] qrs_sample(input logic [3:0] idx);
    qrs_sample = 8'sd0;
    for (int i = 0; i < 9; i++) begin
      if (idx == 4'(i)) qrs_sample = QRS_ROM[i];
    end
  endfunction

endpackage

// File: rtl/ecg_synth_if.sv
// Rate request handshake and sample stream of the synthetic ECG source.
interface ecg_synth_if;
  logic [7:0]        bpm_in;
  logic              bpm_valid;
  logic              bpm_ready;
  logic signed [7:0] xout;
  logic              beat;
  logic              running;

  modport master (output bpm_in, bpm_valid, input bpm_ready, xout, beat, running);
  modport slave  (input bpm_in, bpm_valid, output bpm_ready, xout, beat, running);
endinterface

// File: rtl/ecg_synth_period_divider.sv
// 32-bit restoring divider, one quotient bit per cycle; low OUT_W bits of the
// quotient are presented with a one-cycle done pulse.
module period_divider #(
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      dividend,
  input  logic [31:0]      divisor,
  output logic             ready,
  output logic             done,
  output logic [OUT_W-1:0] quotient
);
  localparam int unsigned W = 32;

  logic [W-1:0] rem;
  logic [W-1:0] dvs;
  logic [W-1:0] quo;
  logic [4:0]   cnt;
  logic [W:0]   shifted;
  logic [W:0]   trial;

  assign shifted  = {rem, quo[W-1]};
  assign trial    = shifted - {1'b0, dvs};
  assign quotient = quo[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready <= 1'b1;
      done  <= 1'b0;
      rem   <= '0;
      dvs   <= '0;
      quo   <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (ready) begin
        if (start) begin
          ready <= 1'b0;
          rem   <= '0;
          dvs   <= divisor;
          quo   <= dividend;
          cnt   <= '0;
        end
      end else begin
        // Negative trial keeps the shifted remainder and shifts in a zero
        if (trial[W]) begin
          rem <= shifted[W-1:0];
          quo <= {quo[W-2:0], 1'b0};
        end else begin
          rem <= trial[W-1:0];
          quo <= {quo[W-2:0], 1'b1};
        end
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          ready <= 1'b1;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ecg_synth.sv
// Synthetic piecewise-linear PQRST source at a requested heart rate.
// Define ECG_SYNTH_NOISE_EN to add saturating LFSR noise to xout.
module ecg_synth
  import ecg_synth_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 200,
  parameter int unsigned BPM_MIN  = DEF_BPM_MIN,
  parameter int unsigned BPM_MAX  = DEF_BPM_MAX,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  ecg_synth_if.slave  bus
);
  localparam logic [31:0] NUMER  = 32'(CLK_FREQ * 60);
  localparam logic [7:0]  BPM_LO = 8'(BPM_MIN);
  localparam logic [7:0]  BPM_HI = 8'(BPM_MAX);

  logic [7:0]          bpm_c;
  logic                accept;
  logic                div_ready;
  logic                div_done;
  logic [PERIOD_W-1:0] div_q;
  logic [PERIOD_W-1:0] pending_period;
  logic                pending_valid;
  logic                take;
  logic [PERIOD_W-1:0] period, period_nxt;
  logic [PERIOD_W-1:0] s, s_nxt;
  logic [STATE_W-1:0]  state, state_nxt;
  logic [7:0]          off;
  logic signed [7:0]   wave_c;
  logic signed [7:0]   xout_c;
  logic                beat_c;

  always_comb begin
    bpm_c = bus.bpm_in;
    if (bus.bpm_in < BPM_LO)      bpm_c = BPM_LO;
    else if (bus.bpm_in > BPM_HI) bpm_c = BPM_HI;
  end

  assign accept        = bus.bpm_valid & div_ready;
  assign bus.bpm_ready = div_ready;

  period_divider #(.OUT_W(PERIOD_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .dividend (NUMER),
    .divisor  ({24'd0, bpm_c}),
    .ready    (div_ready),
    .done     (div_done),
    .quotient (div_q)
  );

  // A fresh result wins over a same-cycle consume so it is never lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_period <= '0;
      pending_valid  <= 1'b0;
    end else if (div_done) begin
      pending_period <= div_q;
      pending_valid  <= 1'b1;
    end else if (take) begin
      pending_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      s      <= '0;
      period <= '0;
    end else begin
      state  <= state_nxt;
      s      <= s_nxt;
      period <= period_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    s_nxt      = s;
    period_nxt = period;
    take       = 1'b0;
    if (state == IDLE) begin
      if (pending_valid) begin
        take       = 1'b1;
        period_nxt = pending_period;
        s_nxt      = '0;
        state_nxt  = P_UP;
      end
    end else begin
      if (s == period - PERIOD_W'(1)) begin
        s_nxt = '0;
        if (pending_valid) begin
          take       = 1'b1;
          period_nxt = pending_period;
        end
      end else begin
        s_nxt = s + PERIOD_W'(1);
      end
      if (s_nxt < PERIOD_W'(SEG_P_DN))      state_nxt = P_UP;
      else if (s_nxt < PERIOD_W'(SEG_PR))   state_nxt = P_DN;
      else if (s_nxt < PERIOD_W'(SEG_QRS))  state_nxt = PR;
      else if (s_nxt < PERIOD_W'(SEG_ST))   state_nxt = QRS;
      else if (s_nxt < PERIOD_W'(SEG_T_UP)) state_nxt = ST;
      else if (s_nxt < PERIOD_W'(SEG_T_DN)) state_nxt = T_UP;
      else if (s_nxt < PERIOD_W'(SEG_TP))   state_nxt = T_DN;
      else                                  state_nxt = TP;
    end
  end

  // Sample value for the index being entered, so it registers alongside s
  always_comb begin
    wave_c = 8'sd0;
    off    = 8'd0;
    case (state_nxt)
      P_UP: begin
        off    = 8'(s_nxt - PERIOD_W'(SEG_P_UP));
        wave_c = 8'((off + 8'd1) << 1);
      end
      P_DN: begin
        off    = 8'(s_nxt - PERIOD_W'(SEG_P_DN));
        wave_c = 8'd10 - 8'(off << 1);
      end
      QRS: begin
        off    = 8'(s_nxt - PERIOD_W'(SEG_QRS));
        wave_c = qrs_sample(off[3:0]);
      end
      T_UP: begin
        off    = 8'(s_nxt - PERIOD_W'(SEG_T_UP));
        wave_c = 8'((off + 8'd1) << 1);
      end
      T_DN: begin
        off    = 8'(s_nxt - PERIOD_W'(SEG_T_DN));
        wave_c = 8'd18 - 8'(off << 1);
      end
      default: wave_c = 8'sd0;
    endcase
  end

  assign beat_c = (state_nxt == QRS) && (s_nxt == PERIOD_W'(SEG_QRS + R_PEAK_OFF));

`ifdef ECG_SYNTH_NOISE_EN
  logic [15:0]       lfsr;
  logic signed [8:0] noisy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 16'hACE1;
    else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign noisy  = $signed({wave_c[7], wave_c}) + $signed({6'd0, lfsr[2:0]}) - 9'sd4;
  assign xout_c = (noisy > 9'sd127)  ? 8'h7F :
                  (noisy < -9'sd128) ? 8'h80 : noisy[7:0];
`else
  assign xout_c = wave_c;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.xout    <= 8'sd0;
      bus.beat    <= 1'b0;
      bus.running <= 1'b0;
    end else begin
      bus.xout <= xout_c;
      bus.beat <= beat_c;
      if (state_nxt != IDLE) bus.running <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ecg_synth.sv
// Self-checking bench for ecg_synth: rate table, shape, rate change, busy hold, reset.
module tb_ecg_synth;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_q[$];
  int   hist[4];

  typedef struct {
    int bpm;
    int period;
  } vec_t;

  vec_t vecs[10];

  ecg_synth_if bus();

  ecg_synth dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.bpm_valid = 1'b0;
    bus.bpm_in = 8'd0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("rst_xout", int'(bus.xout), 0);
    check("rst_beat", int'(bus.beat), 0);
    check("rst_running", int'(bus.running), 0);
    check("rst_ready", int'(bus.bpm_ready), 1);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Issue a request; optionally keep valid high with another value while busy
  task automatic load(input int bpm, input int hold_bpm);
    int lo;
    lo = 0;
    bus.bpm_in = 8'(bpm);
    bus.bpm_valid = 1'b1;
    @(negedge clk);
    if (hold_bpm != 0) bus.bpm_in = 8'(hold_bpm);
    else               bus.bpm_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.bpm_ready) break;
      lo++;
      @(negedge clk);
    end
    bus.bpm_valid = 1'b0;
    check("ready_low_cycles", lo, 32);
  endtask

  task automatic wait_beat(input string name, output int at);
    logic found;
    found = 1'b0;
    at = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.beat) begin
        found = 1'b1;
        at = cyc;
        break;
      end
      hist[0] = hist[1];
      hist[1] = hist[2];
      hist[2] = hist[3];
      hist[3] = int'(bus.xout);
    end
    check({name, "_seen"}, int'(found), 1);
  endtask

  task automatic check_gap(input string name, input int gap);
    int e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    check(name, gap, e);
  endtask

  // Called on the beat cycle: R peak, four samples before and four after
  task automatic check_shape(input string name);
    int pre[4];
    int post[4];
    pre  = '{-5, -10, 30, 65};
    post = '{60, 20, -25, -12};
    check({name, "_peak"}, int'(bus.xout), 100);
    check({name, "_running"}, int'(bus.running), 1);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_pre%0d", name, i), hist[i], pre[i]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("%s_post%0d", name, i), int'(bus.xout), post[i]);
    end
  endtask

  initial begin
    int b0, b1, b2, b3, nbeat, nrun;
    vecs = '{'{72, 166}, '{20, 400}, '{250, 60}, '{120, 100}, '{0, 400},
             '{31, 387}, '{199, 60}, '{201, 60}, '{150, 80}, '{90, 133}};
    rst = 1'b0;
    bus.bpm_valid = 1'b0;
    bus.bpm_in = 8'd0;

    foreach (vecs[v]) begin
      do_reset();
      load(vecs[v].bpm, 0);
      exp_q.push_back(vecs[v].period);
      exp_q.push_back(vecs[v].period);
      wait_beat("vec_b0", b0);
      wait_beat("vec_b1", b1);
      check_shape($sformatf("shape_bpm%0d", vecs[v].bpm));
      check_gap($sformatf("gap1_bpm%0d", vecs[v].bpm), b1 - b0);
      wait_beat("vec_b2", b2);
      check_gap($sformatf("gap2_bpm%0d", vecs[v].bpm), b2 - b1);
    end

    // 72 -> 120 requested at s=80: current beat completes with the old period
    do_reset();
    load(72, 0);
    wait_beat("chg_b0", b0);
    repeat (58) @(negedge clk);
    load(120, 0);
    exp_q.push_back(166);
    exp_q.push_back(100);
    exp_q.push_back(100);
    wait_beat("chg_b1", b1);
    check_gap("chg_gap_old", b1 - b0);
    wait_beat("chg_b2", b2);
    check_gap("chg_gap_new1", b2 - b1);
    wait_beat("chg_b3", b3);
    check_gap("chg_gap_new2", b3 - b2);

    // Clamped low then high rate
    do_reset();
    load(20, 0);
    wait_beat("clamp_b0", b0);
    load(250, 0);
    exp_q.push_back(400);
    exp_q.push_back(60);
    exp_q.push_back(60);
    wait_beat("clamp_b1", b1);
    check_gap("clamp_gap_400", b1 - b0);
    wait_beat("clamp_b2", b2);
    check_gap("clamp_gap_60a", b2 - b1);
    wait_beat("clamp_b3", b3);
    check_gap("clamp_gap_60b", b3 - b2);

    // Valid held with another rate while the divider is busy
    do_reset();
    load(72, 120);
    exp_q.push_back(166);
    exp_q.push_back(166);
    wait_beat("hold_b0", b0);
    wait_beat("hold_b1", b1);
    check_gap("hold_gap1", b1 - b0);
    wait_beat("hold_b2", b2);
    check_gap("hold_gap2", b2 - b1);

    // Asynchronous reset in the middle of the QRS complex
    do_reset();
    load(72, 0);
    wait_beat("mid_b0", b0);
    repeat (165) @(negedge clk);
    check("mid_pre_xout", int'(bus.xout), 65);
    rst = 1'b0;
    #1;
    check("mid_xout", int'(bus.xout), 0);
    check("mid_beat", int'(bus.beat), 0);
    check("mid_running", int'(bus.running), 0);
    check("mid_ready", int'(bus.bpm_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    nbeat = 0;
    nrun = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.beat) nbeat++;
      if (bus.running) nrun++;
    end
    check("post_rst_beats", nbeat, 0);
    check("post_rst_running", nrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
